// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory among NUM_CH valid/ready requesters.
// Read responses come back MEM_LAT cycles after issue, tagged to the issuing channel.
module mem_port_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int ARB_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_we,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  input  logic [NUM_CH*3-1:0]      req_funct3,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  input  logic                     mem_ready,
  output logic                     mem_re,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [2:0]               mem_funct3,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     busy
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PTR_W:0] NUM_CH_W = (PTR_W + 1)'(NUM_CH);

  logic [PTR_W-1:0]  r_rr_ptr;
  logic [MEM_LAT-1:0] r_stg_vld;
  logic [PTR_W-1:0]  r_stg_id [MEM_LAT];

  logic [ADDR_W-1:0] w_ch_addr   [NUM_CH];
  logic [DATA_W-1:0] w_ch_wdata  [NUM_CH];
  logic [2:0]        w_ch_funct3 [NUM_CH];

  logic [PTR_W-1:0]  w_start;
  logic [PTR_W-1:0]  w_sel;
  logic [PTR_W:0]    w_sum;
  logic              w_hit;
  logic              w_accept;
  logic              w_gnt_we;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign w_ch_addr[gi]   = req_addr[gi*ADDR_W +: ADDR_W];
      assign w_ch_wdata[gi]  = req_wdata[gi*DATA_W +: DATA_W];
      assign w_ch_funct3[gi] = req_funct3[gi*3 +: 3];
    end
  endgenerate

  // Walk the channels from the highest offset down so the lowest offset from
  // the start point is the one left in w_sel.
  always_comb begin : p_search
    w_start = (ARB_MODE == 1) ? r_rr_ptr : '0;
    w_sel   = '0;
    w_hit   = 1'b0;
    w_sum   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_sum = {1'b0, w_start} + (PTR_W + 1)'(k);
      if (w_sum >= NUM_CH_W) begin
        w_sum = w_sum - NUM_CH_W;
      end
      if (req_valid[w_sum[PTR_W-1:0]]) begin
        w_sel = w_sum[PTR_W-1:0];
        w_hit = 1'b1;
      end
    end
  end

  assign w_accept = w_hit & mem_ready & ~rst;
  assign w_gnt_we = req_we[w_sel];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_grant
      assign req_ready[gi] = w_accept && (w_sel == PTR_W'(gi));
    end
  endgenerate

  assign mem_re     = w_accept & ~w_gnt_we;
  assign mem_we     = w_accept & w_gnt_we;
  assign mem_addr   = w_accept ? w_ch_addr[w_sel]   : '0;
  assign mem_wdata  = w_accept ? w_ch_wdata[w_sel]  : '0;
  assign mem_funct3 = w_accept ? w_ch_funct3[w_sel] : 3'b000;

  // The pointer only moves in round-robin mode and only with more than one channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_accept && (ARB_MODE == 1) && (NUM_CH > 1)) begin
      if (w_sel == PTR_W'(NUM_CH - 1)) begin
        r_rr_ptr <= '0;
      end else begin
        r_rr_ptr <= w_sel + PTR_W'(1);
      end
    end
  end

  // Read tracking advances unconditionally: memory latency is fixed once issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stg_vld <= '0;
      for (int s = 0; s < MEM_LAT; s++) begin
        r_stg_id[s] <= '0;
      end
    end else begin
      r_stg_vld[0] <= mem_re;
      r_stg_id[0]  <= w_sel;
      for (int s = 1; s < MEM_LAT; s++) begin
        r_stg_vld[s] <= r_stg_vld[s-1];
        r_stg_id[s]  <= r_stg_id[s-1];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rsp
      assign rsp_valid[gi] = r_stg_vld[MEM_LAT-1] && (r_stg_id[MEM_LAT-1] == PTR_W'(gi));
    end
  endgenerate

  assign rsp_rdata = r_stg_vld[MEM_LAT-1] ? mem_rdata : '0;
  assign busy      = |r_stg_vld;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a fixed-priority and a round-robin instance, each with
// its own memory, random requesters, reference arbiter and response scoreboard.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int NC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int n_done = 0;

  typedef struct {
    int          ch;
    logic [31:0] data;
    int          due;
  } rsp_t;

  function automatic logic [31:0] init_val(input int i);
    return 32'hAAAA0000 + 32'(i) * 32'h11110001;
  endfunction

  task automatic check(input string name, input int cfg, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg%0d cyc%0d: got 0x%0h, want 0x%0h", name, cfg, cyc, act, exp);
    end
  endtask

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
      localparam int MODE = gi;
      localparam int LAT  = (gi == 0) ? 2 : 3;

      logic            rst = 1'b0;
      logic [NC-1:0]   req_valid, req_we, req_ready, rsp_valid;
      logic [NC*32-1:0] req_addr, req_wdata;
      logic [NC*3-1:0] req_funct3;
      logic [31:0]     rsp_rdata, mem_addr, mem_wdata, mem_rdata;
      logic            mem_ready, mem_re, mem_we, busy;
      logic [2:0]      mem_funct3;

      mem_port_arbiter #(
        .NUM_CH(NC), .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .ARB_MODE(MODE)
      ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_funct3(req_funct3), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_ready(mem_ready), .mem_re(mem_re), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
        .mem_rdata(mem_rdata), .busy(busy)
      );

      // Memory with a LAT-cycle read pipeline; contents loaded on the first edge.
      logic [31:0] mem [0:7];
      logic        mem_ok = 1'b0;
      logic [31:0] rd_pipe [0:LAT-1];
      always @(posedge clk) begin
        if (!mem_ok) begin
          for (int i = 0; i < 8; i++) mem[i] <= init_val(i);
          mem_ok <= 1'b1;
        end else if (mem_we) begin
          mem[mem_addr[4:2]] <= mem_wdata;
        end
        rd_pipe[0] <= mem_re ? mem[mem_addr[4:2]] : 32'h0;
        for (int s = 1; s < LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
      end
      assign mem_rdata = rd_pipe[LAT-1];

      logic [NC-1:0] pend = '0;
      logic          p_we    [NC];
      logic [31:0]   p_addr  [NC];
      logic [31:0]   p_wdata [NC];
      logic [2:0]    p_f3    [NC];
      for (genvar gj = 0; gj < NC; gj++) begin : g_pack
        assign req_we[gj]              = p_we[gj];
        assign req_addr[gj*32 +: 32]   = p_addr[gj];
        assign req_wdata[gj*32 +: 32]  = p_wdata[gj];
        assign req_funct3[gj*3 +: 3]   = p_f3[gj];
      end
      assign req_valid = pend;

      logic [31:0] model_mem [0:7];
      rsp_t q[$];
      int flush_pt = 0;
      int rr       = 0;
      int last_g   = -1;
      int rd_idx   = 0;

      task automatic step(input bit rv, input int p_new, input bit mr, input int force_ch);
        int g;
        int c;
        logic [2:0] wi;
        rsp_t e;
        @(negedge clk);
        if (last_g >= 0) pend[last_g] = 1'b0;
        last_g    = -1;
        rst       = rv;
        mem_ready = mr;
        if (rv) begin
          flush_pt = q.size();
          rr       = 0;
        end
        for (int ch = 0; ch < NC; ch++) begin
          if (!pend[ch] && ($urandom_range(99) < p_new)) begin
            p_we[ch]    = ($urandom_range(99) < 30);
            p_addr[ch]  = 32'h100 + 32'($urandom_range(7)) * 4;
            p_wdata[ch] = $urandom;
            p_f3[ch]    = 3'($urandom_range(7));
            pend[ch]    = 1'b1;
          end
        end
        if (force_ch >= 0 && !pend[force_ch]) begin
          p_we[force_ch]    = 1'b0;
          p_addr[force_ch]  = 32'h104;
          p_wdata[force_ch] = 32'h0;
          p_f3[force_ch]    = 3'd2;
          pend[force_ch]    = 1'b1;
        end
        #2;
        g = -1;
        if (!rv && mr) begin
          for (int k = 0; k < NC; k++) begin
            c = (MODE == 1) ? (rr + k) % NC : k;
            if (g < 0 && pend[c]) g = c;
          end
        end
        check("req_ready", gi, req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
        if (g >= 0) begin
          check("mem_re", gi, mem_re, !p_we[g]);
          check("mem_we", gi, mem_we, p_we[g]);
          check("mem_addr", gi, mem_addr, p_addr[g]);
          check("mem_wdata", gi, mem_wdata, p_wdata[g]);
          check("mem_funct3", gi, mem_funct3, p_f3[g]);
          wi = p_addr[g][4:2];
          if (p_we[g]) begin
            model_mem[wi] = p_wdata[g];
          end else begin
            e.ch   = g;
            e.data = model_mem[wi];
            e.due  = cyc + LAT;
            q.push_back(e);
          end
          if (MODE == 1) rr = (g + 1) % NC;
          last_g = g;
        end else begin
          check("mem_idle", gi, {mem_re, mem_we, mem_funct3, mem_addr}, 64'd0);
          check("mem_idle_wdata", gi, mem_wdata, 64'd0);
        end
      endtask

      // Response monitor: consumes scoreboard entries as their due cycle arrives.
      always begin
        @(negedge clk);
        #1;
        if (rd_idx < flush_pt) rd_idx = flush_pt;
        check("busy", gi, busy, rd_idx < q.size());
        while (rd_idx < q.size() && q[rd_idx].due < cyc) begin
          checks++;
          errors++;
          $display("FAIL rsp_missing cfg%0d cyc%0d: got none, want ch%0d due %0d",
                   gi, cyc, q[rd_idx].ch, q[rd_idx].due);
          rd_idx++;
        end
        if (rd_idx < q.size() && q[rd_idx].due == cyc) begin
          check("rsp_valid", gi, rsp_valid, 64'd1 << q[rd_idx].ch);
          check("rsp_rdata", gi, rsp_rdata, q[rd_idx].data);
          rd_idx++;
        end else begin
          check("rsp_idle", gi, rsp_valid, 64'd0);
          check("rsp_idle_rdata", gi, rsp_rdata, 64'd0);
        end
      end

      initial begin
        for (int i = 0; i < 8; i++) model_mem[i] = init_val(i);
        for (int ch = 0; ch < NC; ch++) begin
          p_we[ch] = 1'b0; p_addr[ch] = 32'h0; p_wdata[ch] = 32'h0; p_f3[ch] = 3'd0;
        end
        mem_ready = 1'b0;
        #1 rst = 1'b1;
        repeat (3) step(1'b1, 100, 1'b1, -1);
        step(1'b0, 100, 1'b1, -1);
        repeat (2) step(1'b0, 100, 1'b0, -1);
        repeat (12) step(1'b0, 100, 1'b1, -1);
        repeat (400) step(1'b0, 60, ($urandom_range(99) < 80), -1);
        repeat (12) step(1'b0, 0, 1'b1, -1);
        // A read in flight when reset hits must never respond.
        step(1'b0, 0, 1'b1, 1);
        repeat (2) step(1'b1, 0, 1'b1, -1);
        repeat (LAT + 3) step(1'b0, 0, 1'b1, -1);
        repeat (200) step(1'b0, 50, ($urandom_range(99) < 70), -1);
        repeat (12) step(1'b0, 0, 1'b1, -1);
        check("all_rsp_done", gi, rd_idx, q.size());
        n_done++;
      end
    end
  endgenerate

  initial begin
    for (int i = 0; i < 30000 && n_done < 2; i++) @(posedge clk);
    if (n_done < 2) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d configs done, want 2", n_done);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
